// File: rtl/audio_delay_line_ctrl_if.sv
// Sample stream, delay control and RAM port bundle for the audio delay line controller.
// The slave modport is the controller's view; the master modport is its environment.
interface audio_delay_line_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] delay_len;
    logic                  clr_overrun;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  in_valid, in_data, delay_len, clr_overrun, ram_rd_data,
        output ram_addr, ram_wr_data, ram_wr_en, out_valid, out_data, busy, overrun
    );

    modport master (
        output in_valid, in_data, delay_len, clr_overrun, ram_rd_data,
        input  ram_addr, ram_wr_data, ram_wr_en, out_valid, out_data, busy, overrun
    );
endinterface

// File: rtl/audio_delay_line_ctrl.sv
// Circular delay line over a single-port registered-output RAM: for every accepted sample,
// read the sample written delay_len samples earlier, emit it, then write the new sample.
module audio_delay_line_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RAM_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    audio_delay_line_ctrl_if.slave dl
);
    localparam int unsigned CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        WR   = 2'd3
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] fill_q;
    logic [ADDR_WIDTH-1:0] dly_q;
    logic [DATA_WIDTH-1:0] sample_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wr_data_q;
    logic                  ram_wr_en_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic [DATA_WIDTH-1:0] out_data_d;

    // Zero delay bypasses the RAM; locations beyond the fill level were never written.
    always_comb begin
        out_data_d = dl.ram_rd_data;
        if (dly_q == '0) begin
            out_data_d = sample_q;
        end else if (dly_q > fill_q) begin
            out_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            fill_q        <= '0;
            dly_q         <= '0;
            sample_q      <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_en_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;

            // A dropped sample takes priority over a clear in the same cycle.
            if (dl.in_valid && busy_q) begin
                overrun_q <= 1'b1;
            end else if (dl.clr_overrun) begin
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (dl.in_valid) begin
                        sample_q    <= dl.in_data;
                        dly_q       <= dl.delay_len;
                        ram_addr_q  <= wr_ptr_q - dl.delay_len;
                        ram_wr_en_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= RD;
                    end
                end
                RD: begin
                    wait_cnt_q <= CNT_W'(RAM_LAT);
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q <= CNT_W'(1)) begin
                        out_valid_q   <= 1'b1;
                        out_data_q    <= out_data_d;
                        ram_addr_q    <= wr_ptr_q;
                        ram_wr_data_q <= sample_q;
                        ram_wr_en_q   <= 1'b1;
                        state_q       <= WR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                WR: begin
                    ram_wr_en_q <= 1'b0;
                    wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(1);
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + ADDR_WIDTH'(1);
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dl.ram_addr    = ram_addr_q;
    assign dl.ram_wr_data = ram_wr_data_q;
    assign dl.ram_wr_en   = ram_wr_en_q;
    assign dl.out_valid   = out_valid_q;
    assign dl.out_data    = out_data_q;
    assign dl.busy        = busy_q;
    assign dl.overrun     = overrun_q;
endmodule
